// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: bus widths, per-stage payload structs,
// their bubble (NOP) encodings, and the skid-buffer state encoding used
// by pipe_stage_reg.
package pipe_pkg;

  // Bus widths inherited from the original core definitions.
  localparam int WORD_W      = 32;  // WordBus
  localparam int REG_ADDR_W  = 5;   // RegAddrBus
  localparam int INST_ADDR_W = 32;  // InstAddrBus
  localparam int ALU_OP_W    = 8;
  localparam int WB_SEL_W    = 2;

  typedef logic [WORD_W-1:0]      word_t;
  typedef logic [REG_ADDR_W-1:0]  reg_addr_t;
  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [ALU_OP_W-1:0]    alu_op_t;
  typedef logic [WB_SEL_W-1:0]    wb_sel_t;

  // Canonical "do nothing" values from the original core.
  localparam word_t   ZERO_WORD   = '0;
  localparam alu_op_t ALU_NOP     = 8'h00;
  localparam wb_sel_t WB_FROM_NOP = 2'd0;

  // IF/ID payload.
  typedef struct packed {
    inst_addr_t pc;
    word_t      inst;
  } if_id_t;

  // ID/EX payload.
  typedef struct packed {
    alu_op_t   alu_op;
    word_t     reg1;
    word_t     reg2;
    reg_addr_t wd;
    logic      wreg;
    wb_sel_t   wb_sel;
  } id_ex_t;

  // EX/MEM payload.
  typedef struct packed {
    word_t     alu_res;
    word_t     store_data;
    reg_addr_t wd;
    logic      wreg;
    logic      mem_re;
    logic      mem_we;
    wb_sel_t   wb_sel;
  } ex_mem_t;

  // MEM/WB payload.
  typedef struct packed {
    word_t     wdata;
    reg_addr_t wd;
    logic      wreg;
  } mem_wb_t;

  // Bubble encodings: no register write, no memory access, ALU idle.
  localparam if_id_t IF_ID_NOP = '{pc: ZERO_WORD, inst: ZERO_WORD};

  localparam id_ex_t ID_EX_NOP = '{
    alu_op: ALU_NOP, reg1: ZERO_WORD, reg2: ZERO_WORD,
    wd: '0, wreg: 1'b0, wb_sel: WB_FROM_NOP
  };

  localparam ex_mem_t EX_MEM_NOP = '{
    alu_res: ZERO_WORD, store_data: ZERO_WORD, wd: '0, wreg: 1'b0,
    mem_re: 1'b0, mem_we: 1'b0, wb_sel: WB_FROM_NOP
  };

  localparam mem_wb_t MEM_WB_NOP = '{wdata: ZERO_WORD, wd: '0, wreg: 1'b0};

  // Skid-buffer occupancy; the encoding doubles as the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts qualifying cycles and sticks at all-ones.
// Cleared only by reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: step by one unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register carrying an opaque payload over a
// valid/ready link, with separate stall (ready_i low) and flush controls,
// an optional 2-entry skid buffer and saturating stall/bubble counters.
//
// Handshake: an entry moves across a link in any cycle where both valid
// and ready are high on that link (push = valid_i & ready_o upstream,
// pop = valid_o & ready_i downstream). valid is never withdrawn and data
// never changes while valid is high and ready is low.
//
// count_o reflects the occupancy state directly (EMPTY/ONE/TWO encoding
// when SKID=1), so it also serves as the state observation point.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 128,
  parameter int                SKID        = 1,
  parameter logic [DATA_W-1:0] NOP_PAYLOAD = {DATA_W{1'b0}},
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        count_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  logic stall_inc;
  logic bubble_inc;

  generate
    if (SKID != 0) begin : g_skid
      // Main register M drives data_o; skid register S catches the one
      // entry that may arrive while the downstream stalls, which lets
      // ready_o depend on state only.
      skid_state_e       state_q;
      skid_state_e       state_d;
      logic [DATA_W-1:0] m_q;
      logic [DATA_W-1:0] m_d;
      logic [DATA_W-1:0] s_q;
      logic [DATA_W-1:0] s_d;
      logic              push;
      logic              pop;

      // Next-state and register loads; flush dominates any transfer.
      always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        push    = valid_i && (state_q != TWO);
        pop     = (state_q != EMPTY) && ready_i;
        if (flush_i) begin
          state_d = EMPTY;
          m_d     = NOP_PAYLOAD;
          s_d     = NOP_PAYLOAD;
        end else begin
          case (state_q)
            EMPTY: begin
              if (push) begin
                state_d = ONE;
                m_d     = data_i;
              end
            end
            ONE: begin
              if (push && pop) begin
                m_d = data_i;
              end else if (push) begin
                state_d = TWO;
                s_d     = data_i;
              end else if (pop) begin
                state_d = EMPTY;
                m_d     = NOP_PAYLOAD;
              end
            end
            TWO: begin
              if (pop) begin
                state_d = ONE;
                m_d     = s_q;
                s_d     = NOP_PAYLOAD;
              end
            end
            default: begin
              state_d = EMPTY;
              m_d     = NOP_PAYLOAD;
              s_d     = NOP_PAYLOAD;
            end
          endcase
        end
      end

      // State and payload registers.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_q <= EMPTY;
          m_q     <= NOP_PAYLOAD;
          s_q     <= NOP_PAYLOAD;
        end else begin
          state_q <= state_d;
          m_q     <= m_d;
          s_q     <= s_d;
        end
      end

      assign ready_o = (state_q != TWO);
      assign valid_o = (state_q != EMPTY);
      assign data_o  = valid_o ? m_q : NOP_PAYLOAD;
      assign count_o = state_q;
    end else begin : g_single
      // Single register: accepting while full relies on the downstream
      // taking the current entry in the same cycle, so ready_o is
      // combinational from ready_i.
      logic              valid_q;
      logic              valid_d;
      logic [DATA_W-1:0] m_q;
      logic [DATA_W-1:0] m_d;
      logic              push;
      logic              pop;

      // Next-state: flush, then load on push, then drain to bubble on pop.
      always_comb begin
        valid_d = valid_q;
        m_d     = m_q;
        push    = valid_i && (!valid_q || ready_i);
        pop     = valid_q && ready_i;
        if (flush_i) begin
          valid_d = 1'b0;
          m_d     = NOP_PAYLOAD;
        end else if (push) begin
          valid_d = 1'b1;
          m_d     = data_i;
        end else if (pop) begin
          valid_d = 1'b0;
          m_d     = NOP_PAYLOAD;
        end
      end

      // Valid flag and payload register.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
          m_q     <= NOP_PAYLOAD;
        end else begin
          valid_q <= valid_d;
          m_q     <= m_d;
        end
      end

      assign ready_o = !valid_q || ready_i;
      assign valid_o = valid_q;
      assign data_o  = valid_q ? m_q : NOP_PAYLOAD;
      assign count_o = {1'b0, valid_q};
    end
  endgenerate

  // Performance qualifiers look at the outputs as presented this cycle,
  // so a flush cycle still counts.
  assign stall_inc  = valid_o && !ready_i;
  assign bubble_inc = !valid_o && ready_i;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (bubble_inc),
    .cnt_o (bubble_cnt_o)
  );

endmodule
